ym_recorder: RTL

- Captures writes to the YM2149 and records one 16-byte register snapshot per video frame into a RAM, in the non-interleaved YM frame layout (frame*16 + register).
- It is the write-side counterpart of the music player. The CPU or test harness drives the YM2149 directly; this block snoops that bus and produces RAM contents that the player can later replay as frame data.
- Control uses the same 4-byte register window as the player: command register plus a 24-bit base address.

---
 rtl/ym_recorder_pkg.sv | 40 ++++
 rtl/ym_recorder_shadow_regs.sv | 53 +++++
 rtl/ym_recorder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ym_recorder_pkg.sv
// Shared YM2149 definitions for the frame recorder and player: register
// layout, write masks, command codes and recorder states.
package ym_recorder_pkg;

  localparam int YM_REGCOUNT    = 16;
  localparam int YM_FRAME_BYTES = 16;
  localparam int YM_SHADOW_REGS = 14;

  // Bits each YM2149 register actually implements, R13 first.
  localparam logic [YM_SHADOW_REGS-1:0][7:0] YM_REG_MASK = {
    8'h0F, 8'hFF, 8'hFF, 8'h1F, 8'h1F, 8'h1F, 8'hFF,
    8'h1F, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF
  };

  localparam logic [7:0] CMD_PLAY  = 8'd1;
  localparam logic [7:0] CMD_START = 8'd1;
  localparam logic [7:0] CMD_STOP  = 8'd2;

  // R13 byte value meaning "envelope shape not rewritten this frame".
  localparam logic [7:0] YM_NO_ENV = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DUMP  = 2'd2
  } rec_state_e;

  function automatic logic [7:0] ym_frame_byte(
    input logic [3:0]                     idx,
    input logic [YM_SHADOW_REGS-1:0][7:0] snap,
    input logic                           snap13
  );
    logic [7:0] b;
    b = 8'h00;
    if (idx < 4'd13)       b = snap[idx];
    else if (idx == 4'd13) b = snap13 ? snap[13] : YM_NO_ENV;
    return b;
  endfunction

endpackage

// File: rtl/ym_recorder_shadow_regs.sv
// Masked shadow copy of the YM2149 registers seen on the snooped bus, plus the
// per-frame snapshot that the recorder dumps to RAM.
module ym_shadow_regs import ym_recorder_pkg::*; (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ym_wr,
  input  logic [3:0]                       ym_addr,
  input  logic [7:0]                       ym_data,
  input  logic                             snap,
  output logic [YM_SHADOW_REGS-1:0][7:0]   snapshot,
  output logic                             snap13_flag
);

  logic [YM_SHADOW_REGS-1:0][7:0] r_shadow;
  logic [YM_SHADOW_REGS-1:0][7:0] r_snapshot;
  logic                           r_r13_flag;
  logic                           r_snap13;
  logic                           w_r13_wr;

  assign w_r13_wr = ym_wr && (ym_addr == 4'd13);

  // Addresses 14/15 are the I/O ports and never match a shadow slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (ym_wr) begin
      for (int i = 0; i < YM_SHADOW_REGS; i++) begin
        if (ym_addr == 4'(i)) r_shadow[i] <= ym_data & YM_REG_MASK[i];
      end
    end
  end

  // A retrigger written in the snapshot cycle belongs to the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_r13_flag <= 1'b0;
    else if (w_r13_wr) r_r13_flag <= 1'b1;
    else if (snap)     r_r13_flag <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_snapshot <= '0;
      r_snap13   <= 1'b0;
    end else if (snap) begin
      r_snapshot <= r_shadow;
      r_snap13   <= r_r13_flag;
    end
  end

  assign snapshot    = r_snapshot;
  assign snap13_flag = r_snap13;

endmodule

// File: rtl/ym_recorder.sv
// YM2149 frame recorder: snoops register writes and stores one 16-byte
// snapshot per vblank into RAM at base + frame*16.
module ym_recorder import ym_recorder_pkg::*; #(
  parameter int RAM_WIDTH  = 17,
  parameter int MAX_FRAMES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vblank,
  input  logic [1:0]           addr,
  input  logic [7:0]           data_in,
  input  logic                 write,
  input  logic [3:0]           ym_addr,
  input  logic [7:0]           ym_data,
  input  logic                 ym_wr,
  output logic [RAM_WIDTH-1:0] ram_addr,
  output logic [7:0]           ram_data,
  output logic                 ram_we,
  output logic                 recording,
  output logic [15:0]          frame_count
);

  rec_state_e                     r_state, w_state_nxt;
  logic [7:0]                     r_cmd, r_base_h, r_base_m, r_base_l;
  logic                           r_vblank_last;
  logic                           r_stop_pend, w_stop_pend_nxt;
  logic [RAM_WIDTH-1:0]           r_wptr, w_wptr_nxt, w_base;
  logic [3:0]                     r_idx, w_idx_nxt;
  logic [15:0]                    r_frames, w_frames_nxt, w_frames_inc;
  logic                           w_cmd_ack, w_start, w_stop, w_edge, w_snap;
  logic                           w_snap13;
  logic [YM_SHADOW_REGS-1:0][7:0] w_snapshot;

  ym_shadow_regs u_shadow (
    .clk         (clk),
    .reset       (reset),
    .ym_wr       (ym_wr),
    .ym_addr     (ym_addr),
    .ym_data     (ym_data),
    .snap        (w_snap),
    .snapshot    (w_snapshot),
    .snap13_flag (w_snap13)
  );

  // Commands wait for a write-free cycle so a multi-byte setup is never split.
  assign w_cmd_ack    = !write && (r_cmd == CMD_START || r_cmd == CMD_STOP);
  assign w_start      = w_cmd_ack && (r_cmd == CMD_START);
  assign w_stop       = w_cmd_ack && (r_cmd == CMD_STOP);
  assign w_edge       = vblank && !r_vblank_last;
  assign w_base       = RAM_WIDTH'({r_base_h, r_base_m, r_base_l});
  assign w_frames_inc = r_frames + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd    <= '0;
      r_base_h <= '0;
      r_base_m <= '0;
      r_base_l <= '0;
    end else if (write) begin
      case (addr)
        2'd0:    r_cmd    <= data_in;
        2'd1:    r_base_h <= data_in;
        2'd2:    r_base_m <= data_in;
        default: r_base_l <= data_in;
      endcase
    end else if (w_cmd_ack) begin
      r_cmd <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_vblank_last <= 1'b0;
      r_stop_pend   <= 1'b0;
      r_wptr        <= '0;
      r_idx         <= '0;
      r_frames      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_vblank_last <= vblank;
      r_stop_pend   <= w_stop_pend_nxt;
      r_wptr        <= w_wptr_nxt;
      r_idx         <= w_idx_nxt;
      r_frames      <= w_frames_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_stop_pend_nxt = r_stop_pend;
    w_wptr_nxt      = r_wptr;
    w_idx_nxt       = r_idx;
    w_frames_nxt    = r_frames;
    w_snap          = 1'b0;
    if (w_start) begin
      // Start from any state restarts the take; a dump in flight is abandoned.
      w_state_nxt     = ST_ARMED;
      w_stop_pend_nxt = 1'b0;
      w_wptr_nxt      = w_base;
      w_idx_nxt       = '0;
      w_frames_nxt    = '0;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_stop) begin
            w_state_nxt = ST_IDLE;
          end else if (w_edge) begin
            w_snap      = 1'b1;
            w_idx_nxt   = '0;
            w_state_nxt = ST_DUMP;
          end
        end
        ST_DUMP: begin
          if (w_stop) w_stop_pend_nxt = 1'b1;
          w_idx_nxt = r_idx + 4'd1;
          if (r_idx == 4'(YM_FRAME_BYTES - 1)) begin
            w_wptr_nxt   = r_wptr + RAM_WIDTH'(YM_FRAME_BYTES);
            w_frames_nxt = w_frames_inc;
            if (w_frames_inc == 16'(MAX_FRAMES) || w_stop || r_stop_pend) begin
              w_state_nxt     = ST_IDLE;
              w_stop_pend_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_ARMED;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Decoded straight from state so an async reset drops the write strobe at once.
  assign ram_we      = (r_state == ST_DUMP);
  assign ram_addr    = ram_we ? r_wptr + RAM_WIDTH'(r_idx) : '0;
  assign ram_data    = ram_we ? ym_frame_byte(r_idx, w_snapshot, w_snap13) : 8'h00;
  assign recording   = (r_state != ST_IDLE);
  assign frame_count = r_frames;

endmodule
